mem_line_responder: RTL
=======================

# mem_line_responder

Main-memory responder at the far end of the cache line-fill interface. It serves line-read requests from the instruction cache (fetch side) and line-read/line-write requests from the data cache (cache stage) over two independent req/ack ports. Requests are arbitrated round-robin and served one at a time with a fixed, parameterised access latency. It is the memory model instantiated beside `proc` in the system top and the bench.

## Interface
Parameters:
- LATENCY, 10, cycles from request acceptance to ack; legal range 2..255
- LINE_BITS, 128, line width in bits (8 × 16-bit words)
- INDEX_BITS, 8, number of line-index bits; memory depth = 2^INDEX_BITS lines

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- ic_req  in  1  icache line-read request; held high with ic_addr stable until ic_ack
- ic_addr  in  16  byte address; line index = ic_addr[INDEX_BITS+3:4], low 4 bits ignored
- ic_ack  out  1  one-cycle pulse; ic_data valid in that cycle
- ic_data  out  LINE_BITS  read line; holds its value until the next ic_ack
- dc_req  in  1  dcache request; held high with dc_we/dc_addr/dc_wdata stable until dc_ack
- dc_we  in  1  1 = line write, 0 = line read
- dc_addr  in  16  byte address, indexed as for ic_addr
- dc_wdata  in  LINE_BITS  write line
- dc_ack  out  1  one-cycle pulse; read data valid, or write committed
- dc_rdata  out  LINE_BITS  read line; holds until the next dc read ack; unchanged by writes
- busy  out  1  high in WAIT and RESP

## Operation
- FSM: IDLE → WAIT → RESP → IDLE.
- IDLE:
  - If any req is high, grant one requester, latch its address, we and wdata, load cnt = LATENCY-2, go to WAIT.
  - With no requests, stay in IDLE.
- WAIT: decrement cnt; at cnt == 0 go to RESP. Requests and inputs are not sampled in WAIT.
- RESP:
  - Pulse the granted port's ack for one cycle.
  - Read: ic_data or dc_rdata is loaded from mem[index] on the edge entering RESP, so the value is visible during the ack cycle.
  - Write: mem[index] <= latched wdata on the edge leaving RESP.
  - Always return to IDLE.
- Arbitration:
  - Only one requester pending: that requester wins.
  - Both pending: the port not granted last time wins. The last-grant flag resets to "icache", so dcache wins the first tie.
- A requester that keeps req high in the cycle after its ack starts a new transaction, which is sampled in IDLE on that cycle.
- Write followed by read of the same line returns the new data, because transactions are strictly serialised.
- Address bits above INDEX_BITS+3 are ignored; the index wraps.

## Timing
- Request sampled in IDLE at edge t → ack high in cycle t+LATENCY.
- Back-to-back throughput is one transaction per LATENCY+1 cycles (IDLE re-entry cycle included).
- Reset values: ic_ack=0, dc_ack=0, ic_data=0, dc_rdata=0, busy=0, state=IDLE, last-grant=icache.
- Reset mid-transaction:
  - Abort to IDLE with no ack.
  - A pending write is discarded.
  - Memory array contents are not reset.
- req dropped before ack (protocol violation): the transaction still completes and acks, using the latched values.

## Configuration
- MEMRESP_STATS_EN defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0].
  - rd_count increments on every read ack (either port); wr_count increments on every write ack.
  - Both counters saturate at 16'hFFFF and reset to 0.
- MEMRESP_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package mem_pkg holds:
  - state enum (S_IDLE, S_WAIT, S_RESP)
  - grant encoding (GNT_IC, GNT_DC)
  - LINE_BITS default
  - line-offset width constant (4)
- Sub-module mem_rr_arbiter: two-input round-robin arbiter with inputs ic_req, dc_req, last_grant and outputs grant/valid. Purely combinational; last_grant is a register in the parent.
- Memory array and FSM live in the top module.

## Test plan
- Reset, then dc write at 16'h0040 with wdata = 128'h0123…CDEF, then ic read at 16'h0040 → dc_ack at cycle +10; ic_ack at +10 after IDLE re-entry; ic_data = 128'h0123…CDEF.
- ic_req and dc_req rise in the same cycle after reset → dc served first (dc_ack at +10); ic_ack follows exactly 11 cycles after dc_ack.
- Both requesters hold req continuously for 4 transactions → grants alternate DC, IC, DC, IC; acks spaced 11 cycles apart.
- dc write to 16'h0040, then dc read of 16'h1040 with INDEX_BITS=8 → index wraps to line 4; read returns the written line.
- Assert reset 5 cycles into a dc write of 16'h0080 → no dc_ack, busy=0 next cycle; a subsequent read of 16'h0080 returns the previous contents.
- With MEMRESP_STATS_EN: 3 reads and 2 writes → rd_count = 3, wr_count = 2; after reset both are 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the main-memory line responder.
// Used by mem_rr_arbiter and mem_line_responder.
package mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IC = 1'b0,
        GNT_DC = 1'b1
    } grant_t;

    localparam int LINE_BITS_DEF = 128;
    localparam int LINE_OFS_BITS = 4;
    localparam int ADDR_BITS     = 16;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-input round-robin arbiter between icache and dcache line requests.
// Purely combinational; the last-grant register is held by the parent.
module mem_rr_arbiter
    import mem_pkg::*;
(
    input  logic   ic_req,
    input  logic   dc_req,
    input  grant_t last_grant,
    output grant_t grant,
    output logic   valid
);

    always_comb begin
        valid = ic_req | dc_req;
        grant = GNT_IC;
        if (ic_req && dc_req) begin
            // on a tie the port that did not win last time goes first
            grant = (last_grant == GNT_IC) ? GNT_DC : GNT_IC;
        end else if (dc_req) begin
            grant = GNT_DC;
        end
    end

endmodule

// File: rtl/mem_line_responder.sv
// Main-memory line responder serving icache reads and dcache reads/writes with fixed latency.
// Optional MEMRESP_STATS_EN adds saturating read/write ack counters (rd_count, wr_count).
module mem_line_responder
    import mem_pkg::*;
#(
    parameter int LATENCY    = 10,
    parameter int LINE_BITS  = LINE_BITS_DEF,
    parameter int INDEX_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ic_req,
    input  logic [ADDR_BITS-1:0] ic_addr,
    output logic                 ic_ack,
    output logic [LINE_BITS-1:0] ic_data,
    input  logic                 dc_req,
    input  logic                 dc_we,
    input  logic [ADDR_BITS-1:0] dc_addr,
    input  logic [LINE_BITS-1:0] dc_wdata,
    output logic                 dc_ack,
    output logic [LINE_BITS-1:0] dc_rdata,
    output logic                 busy
`ifdef MEMRESP_STATS_EN
    ,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count
`endif
);

    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 2);
    localparam int         DEPTH    = 2 ** INDEX_BITS;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [7:0]              r_cnt;
    grant_t                  r_grant;
    grant_t                  r_last_grant;
    logic                    r_we;
    logic [INDEX_BITS-1:0]   r_idx;
    logic [LINE_BITS-1:0]    r_wdata;
    logic [LINE_BITS-1:0]    r_ic_data;
    logic [LINE_BITS-1:0]    r_dc_rdata;
    logic [LINE_BITS-1:0]    r_mem [DEPTH];

    grant_t                  w_grant;
    logic                    w_valid;
    logic [ADDR_BITS-1:0]    w_addr_sel;
    logic [INDEX_BITS-1:0]   w_idx;
    logic                    w_unused;

    mem_rr_arbiter u_arb (
        .ic_req     (ic_req),
        .dc_req     (dc_req),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .valid      (w_valid)
    );

    assign w_addr_sel = (w_grant == GNT_DC) ? dc_addr : ic_addr;
    assign w_idx      = w_addr_sel[INDEX_BITS+LINE_OFS_BITS-1:LINE_OFS_BITS];
    // offset and above-index address bits are deliberately ignored
    assign w_unused   = ^{ic_addr, dc_addr};

    assign ic_data  = r_ic_data;
    assign dc_rdata = r_dc_rdata;

    always_comb begin
        w_state_nxt = r_state;
        ic_ack      = 1'b0;
        dc_ack      = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_valid) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (r_cnt == 8'd0) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                busy        = 1'b1;
                ic_ack      = (r_grant == GNT_IC);
                dc_ack      = (r_grant == GNT_DC);
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_grant      <= GNT_IC;
            r_last_grant <= GNT_IC;
            r_we         <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_ic_data    <= '0;
            r_dc_rdata   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant;
                        r_we         <= (w_grant == GNT_DC) && dc_we;
                        r_idx        <= w_idx;
                        r_wdata      <= dc_wdata;
                        r_cnt        <= CNT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else if (!r_we) begin
                        // read data lands on the edge entering RESP
                        if (r_grant == GNT_IC) r_ic_data  <= r_mem[r_idx];
                        else                   r_dc_rdata <= r_mem[r_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    // array is never reset; a reset coinciding with RESP drops the write
    always_ff @(posedge clk) begin
        if (!reset && r_state == S_RESP && r_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

`ifdef MEMRESP_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else if (r_state == S_RESP) begin
            if (!r_we && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            if (r_we && wr_count != 16'hFFFF)  wr_count <= wr_count + 16'd1;
        end
    end
`endif

endmodule
